// File: rtl/uart_rx_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register decode,
// STATUS bit positions and receive FSM state encodings.
package uart_rx_pkg;

  // mem_addr bit that selects STATUS (1) versus DATA (0)
  localparam int REG_SEL_BIT = 2;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAMING   = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic logic [31:0] pack_status(input logic       not_empty,
                                              input logic       full,
                                              input logic       overrun,
                                              input logic       framing,
                                              input logic [7:0] count);
    logic [31:0] s;
    s                         = '0;
    s[STAT_NOT_EMPTY]         = not_empty;
    s[STAT_FULL]              = full;
    s[STAT_OVERRUN]           = overrun;
    s[STAT_FRAMING]           = framing;
    s[STAT_COUNT_LSB +: 8]    = count;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with first-word-fall-through output. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  // A pop frees the slot this cycle, so a push into a full FIFO may proceed
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver on the picorv32 bus: synchroniser, mid-bit sampling FSM,
// receive FIFO and DATA/STATUS registers with a one-cycle registered ack.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | half-bit wait, then confirm start bit is still low
// RX_DATA  | sample 8 data bits LSB-first, one per bit period
// RX_STOP  | sample stop bit, push byte or flag framing error
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        serialIn
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW       = $clog2(BAUD_DIV);
  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BIT_RELOAD  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_RELOAD = BW'(BAUD_DIV / 2 - 1);

  logic rx_meta, rx_sync, rx_prev, rx_fall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= serialIn;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  rx_state_t     state, state_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic [2:0]    bidx, bidx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          rx_done, frm_set;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RX_IDLE;
      bcnt  <= '0;
      bidx  <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      bidx  <= bidx_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    bidx_nxt  = bidx;
    shreg_nxt = shreg;
    rx_done   = 1'b0;
    frm_set   = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rx_fall) begin
          bcnt_nxt  = HALF_RELOAD;
          state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (bcnt != '0) begin
          bcnt_nxt = bcnt - 1'b1;
        end else if (!rx_sync) begin
          bcnt_nxt  = BIT_RELOAD;
          bidx_nxt  = '0;
          state_nxt = RX_DATA;
        end else begin
          state_nxt = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (bcnt != '0) begin
          bcnt_nxt = bcnt - 1'b1;
        end else begin
          shreg_nxt = {rx_sync, shreg[7:1]};
          bcnt_nxt  = BIT_RELOAD;
          bidx_nxt  = bidx + 1'b1;
          if (bidx == 3'd7) state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bcnt != '0) begin
          bcnt_nxt = bcnt - 1'b1;
        end else begin
          rx_done   = rx_sync;
          frm_set   = ~rx_sync;
          state_nxt = RX_IDLE;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          ovr_set;

  assign fifo_push = rx_done & (~fifo_full | fifo_pop);
  assign ovr_set   = rx_done & fifo_full & ~fifo_pop;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .din    (shreg),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  logic        bus_req, is_write, sel_status;
  logic        ready_q, pop_pend, clr_pend, status_clr;
  logic        overrun, framing;
  logic [31:0] rdata_q, status_word, data_word;

  assign bus_req    = mem_valid & enable & ~mem_ready;
  assign is_write   = |mem_wstrb;
  assign sel_status = mem_addr[REG_SEL_BIT];

  assign status_word = pack_status(~fifo_empty, fifo_full, overrun, framing, 8'(fifo_count));
  assign data_word   = fifo_empty ? 32'h0 : {23'b0, 1'b1, fifo_dout};

  // Pop/clear decisions are taken against the request-cycle state and
  // applied in the ack cycle, so a byte landing in between is never lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      pop_pend <= 1'b0;
      clr_pend <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ready_q  <= bus_req;
      pop_pend <= bus_req & ~is_write & ~sel_status & ~fifo_empty;
      clr_pend <= bus_req & is_write & sel_status;
      if (bus_req && !is_write) rdata_q <= sel_status ? status_word : data_word;
      else                      rdata_q <= '0;
    end
  end

  assign fifo_pop   = pop_pend & enable;
  assign status_clr = clr_pend & enable;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun <= 1'b0;
      framing <= 1'b0;
    end else begin
      overrun <= ovr_set | (overrun & ~status_clr);
      framing <= frm_set | (framing & ~status_clr);
    end
  end

  assign mem_ready = ready_q & enable;
  assign mem_rdata = enable ? rdata_q : 32'h0;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{mem_instr, mem_wdata, mem_addr[31:3], mem_addr[1:0]};

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a 64-cycle bit period: single byte, glitch,
// overrun, framing, full-boundary pop/push, reset mid-frame, deselect.
module tb_uart_rx;

  localparam int CLK_FREQ = 64000000;
  localparam int BAUD     = 1000000;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        serialIn;

  int errors = 0;
  int checks = 0;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .serialIn  (serialIn)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1; each bit is held for DIV cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serialIn = bits[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                          output logic [31:0] rdata);
    logic got;
    got       = 1'b0;
    mem_addr  = addr;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (mem_ready) got = 1'b1;
    end
    rdata = mem_rdata;
    chk("ack", {31'b0, got}, 32'h1);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;

  initial begin
    resetn    = 1'b0;
    enable    = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = 32'h0;
    mem_wstrb = 4'h0;
    mem_wdata = 32'h0;
    serialIn  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, mem_ready}, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    bus_xfer(32'h4, 4'h0, rd);  chk("rst_status", rd, 32'h0);

    send_frame(8'hA5, 1'b1);
    bus_xfer(32'h4, 4'h0, rd);  chk("single_status", rd, 32'h101);
    bus_xfer(32'h0, 4'h0, rd);  chk("single_data", rd, 32'h1A5);
    bus_xfer(32'h4, 4'h0, rd);  chk("single_status2", rd, 32'h0);

    serialIn = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    serialIn = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    bus_xfer(32'h4, 4'h0, rd);  chk("glitch_status", rd, 32'h0);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    bus_xfer(32'h4, 4'h0, rd);  chk("ovr_status", rd, 32'h807);
    for (int i = 0; i < 8; i++) begin
      bus_xfer(32'h0, 4'h0, rd);
      chk("ovr_drain", rd, 32'h101 + 32'(i));
    end
    bus_xfer(32'h0, 4'h0, rd);  chk("ovr_empty_read", rd, 32'h0);
    bus_xfer(32'h4, 4'h0, rd);  chk("ovr_sticky", rd, 32'h4);
    bus_xfer(32'h4, 4'hF, rd);
    bus_xfer(32'h4, 4'h0, rd);  chk("ovr_cleared", rd, 32'h0);

    send_frame(8'h3C, 1'b0);
    serialIn = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
    bus_xfer(32'h4, 4'h0, rd);  chk("frm_status", rd, 32'h8);
    send_frame(8'h55, 1'b1);
    bus_xfer(32'h4, 4'h0, rd);  chk("frm_next_status", rd, 32'h109);
    bus_xfer(32'h0, 4'h0, rd);  chk("frm_next_data", rd, 32'h155);
    bus_xfer(32'h4, 4'hF, rd);
    bus_xfer(32'h4, 4'h0, rd);  chk("frm_cleared", rd, 32'h0);

    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1);
    bus_xfer(32'h4, 4'h0, rd);  chk("full_status", rd, 32'h803);
    // Stop-bit push lands 611 cycles after the start edge is driven; the
    // read request is timed so its ack cycle is that same cycle.
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (609) @(posedge clk);
        #1;
        bus_xfer(32'h0, 4'h0, rd);
        chk("full_pop_data", rd, 32'h111);
      end
    join
    bus_xfer(32'h4, 4'h0, rd);  chk("full_after_status", rd, 32'h803);
    for (int i = 0; i < 7; i++) begin
      bus_xfer(32'h0, 4'h0, rd);
      chk("full_drain", rd, 32'h112 + 32'(i));
    end
    bus_xfer(32'h0, 4'h0, rd);  chk("full_last", rd, 32'h177);

    send_frame(8'h5A, 1'b1);
    bus_xfer(32'h0, 4'hF, rd);
    bus_xfer(32'h4, 4'h0, rd);  chk("data_write_ignored", rd, 32'h101);
    serialIn = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    serialIn = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
    serialIn  = 1'b0;
    mem_addr  = 32'h0;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_ready", {31'b0, mem_ready}, 32'h1);
    chk("pre_rst_rdata", mem_rdata, 32'h15A);
    resetn = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, mem_ready}, 32'h0);
    chk("mid_rst_rdata", mem_rdata, 32'h0);
    mem_valid = 1'b0;
    serialIn  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (12 * DIV) @(posedge clk);
    #1;
    bus_xfer(32'h4, 4'h0, rd);  chk("post_rst_status", rd, 32'h0);

    enable    = 1'b0;
    mem_addr  = 32'h4;
    mem_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("desel_ready", {31'b0, mem_ready}, 32'h0);
      chk("desel_rdata", mem_rdata, 32'h0);
    end
    mem_valid = 1'b0;
    enable    = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
